stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM that sequences the 2-digit BCD up counter and 7-segment display path as a stopwatch. It debounces and one-pulses two raw buttons, and gates the divider tick into a count enable. It issues counter clears, freezes a lap value for display, and blinks the digits while paused. It sits between the frequency divider/buttons and the counter/display scanner in the lab top level.

Parameters:
CNT_BITS, 8, width of counter value (two BCD digits)
DB_LEN, 4, clk cycles a raw button must be stable before its debounced level changes
BLINK_TICKS, 2, tick pulses per blink half-period in PAUSE
STOP_AT_MAX, 1, 1 = stop counting at 8'h99 and enter PAUSE instead of wrapping

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
btn_ss  in  1  raw start/stop button, active-high, asynchronous to clk
btn_lap  in  1  raw lap/clear button, active-high
tick  in  1  one-clk pulse from frequency divider, count rate
q  in  CNT_BITS  current BCD counter value
cnt_en  out  1  counter increment enable
cnt_clr  out  1  one-cycle synchronous clear to counter
disp_val  out  CNT_BITS  value routed to digit extract/segment decode
digit_blank  out  4  per-digit blank mask to display scanner, 1 = blank
state  out  2  current FSM state, for debug LEDs

Behaviour:
- Reset (rst=0, async): state=IDLE, lap_reg=0, cnt_clr=0, blink_cnt=0, blink_phase=0, digit_blank=4'b1100, debouncer shift registers and last-level flops=0. Release is synchronous to the next clk edge.
- Input conditioning: each button passes through a 2-flop synchronizer. The debounced level flips only after DB_LEN consecutive equal samples. ss_p/lap_p is a 1-clk pulse on the debounced rising edge. Press-to-pulse latency = 2 + DB_LEN clk. Holding a button yields exactly one pulse.
- States (encoding): IDLE=00, RUN=01, PAUSE=10, LAP=11.
- IDLE:
  - ss_p -> RUN.
  - lap_p -> stay IDLE, cnt_clr pulses next cycle.
- RUN:
  - ss_p -> PAUSE.
  - lap_p -> LAP, lap_reg <= q on the same edge.
- LAP (counter keeps running, display frozen):
  - lap_p -> RUN.
  - ss_p -> PAUSE; the display returns to live q.
- PAUSE:
  - ss_p -> RUN.
  - lap_p -> IDLE, cnt_clr pulses next cycle.
- Simultaneous ss_p and lap_p: ss_p wins, lap_p is dropped.
- cnt_en is combinational: tick & (state==RUN | state==LAP) & ~max_hit, where max_hit = STOP_AT_MAX & (q==8'h99).
- Max reached: if max_hit and tick in RUN/LAP -> PAUSE next edge, and no increment is issued. With STOP_AT_MAX=0, the counter wraps 99->00 and the FSM is unaffected.
- cnt_clr is registered and exactly 1 cycle wide. It never coincides with cnt_en, because the FSM is in IDLE or PAUSE when it asserts.
- disp_val = lap_reg in LAP, otherwise q. It is combinational.
- Blink: blink_cnt counts ticks only in PAUSE. At BLINK_TICKS-1 it wraps to 0 and toggles blink_phase. blink_cnt and blink_phase clear to 0 on any exit from PAUSE.
- digit_blank is registered. digit_blank[3:2]=2'b11 always (unused digits). digit_blank[1:0] = {2{blink_phase}} in PAUSE, 2'b00 otherwise.
- Reset asserted mid-RUN or mid-LAP: immediate IDLE and lap_reg clear. The counter itself is not cleared by this block; it shares rst.

Decomposition:
- Shared package/header: state encodings (IDLE/RUN/PAUSE/LAP), BCD_MAX 8'h99, digit_blank unused-digit constant 2'b11.
- One natural sub-module, debounce_onepulse (sync + DB_LEN stable filter + rising-edge pulse), instantiated twice.
- FSM, lap register and blink logic stay in stopwatch_ctrl.

Test Plan:
- Reset then btn_ss held 10 clk -> exactly one ss_p; state 00->01 at 2+DB_LEN+1 clk; cnt_en follows every tick.
- RUN, q=8'h37, press lap -> state=11, disp_val stays 8'h37 while q advances; press lap again -> disp_val tracks q.
- RUN, press start/stop -> state=10, cnt_en=0 on ticks; digit_blank toggles 4'b1100<->4'b1111 every 2 ticks; press lap -> state=00, one-cycle cnt_clr.
- STOP_AT_MAX=1, q=8'h99, tick in RUN -> cnt_en=0, state=10 next clk; with STOP_AT_MAX=0 -> cnt_en=1, state stays 01.
- Both buttons pressed in the same cycle while RUN -> state=10, lap_reg unchanged.
- rst pulled low mid-LAP asynchronously (between clk edges) -> state=00, lap_reg=0, digit_blank=4'b1100 without waiting for a clk edge.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller slice.
// Holds the FSM state encoding, the BCD terminal count, the blank value for
// the two unused display digits, and a helper that builds the blank mask.
package stopwatch_ctrl_pkg;

  // Encoding is visible on the debug LEDs, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_e;

  // Two-digit BCD terminal count.
  localparam logic [7:0] BCD_MAX = 8'h99;

  // Upper two digits of the scanner are not populated by this design.
  localparam logic [1:0] BLANK_UNUSED = 2'b11;

  // Full 4-digit blank mask: unused digits always blank, live digits
  // blank only during the off half of the pause blink.
  function automatic logic [3:0] blank_mask(input logic in_pause, input logic phase);
    return {BLANK_UNUSED, {2{in_pause & phase}}};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle between the stopwatch controller and its neighbours.
// Inputs to the controller: raw buttons, divider tick, live counter value.
// Outputs from the controller: count enable, counter clear, display value,
// digit blank mask and debug state.
//   master : lab top level / counter / scanner side
//   slave  : stopwatch_ctrl
interface stopwatch_ctrl_if #(
  parameter int unsigned CNT_BITS = 8
);

  logic                btn_ss;
  logic                btn_lap;
  logic                tick;
  logic [CNT_BITS-1:0] q;
  logic                cnt_en;
  logic                cnt_clr;
  logic [CNT_BITS-1:0] disp_val;
  logic [3:0]          digit_blank;
  logic [1:0]          state;

  modport master (
    output btn_ss, btn_lap, tick, q,
    input  cnt_en, cnt_clr, disp_val, digit_blank, state
  );

  modport slave (
    input  btn_ss, btn_lap, tick, q,
    output cnt_en, cnt_clr, disp_val, digit_blank, state
  );

endinterface

// File: rtl/stopwatch_ctrl_debounce_onepulse.sv
// Button conditioner: 2-flop synchronizer, DB_LEN-sample stability filter
// and a one-clock pulse on the debounced rising edge.
// Ports:
//   clk, rst : clock, async active-low reset
//   btn      : raw active-high button, asynchronous to clk
//   pulse_c  : one-clk pulse, 2 + DB_LEN clk after the press reaches btn
module stopwatch_ctrl_debounce_onepulse #(
  parameter int unsigned DB_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse_c
);

  logic              sync1;
  logic              sync2;
  logic [DB_LEN-1:0] shift;
  logic [DB_LEN-1:0] shift_d;
  logic              level;
  logic              level_last;

  // Window including the sample being shifted in this cycle, so the level
  // flips on the same edge the DB_LEN-th equal sample is taken.
  assign shift_d = DB_LEN'({shift, sync2});

  // Synchronizer, sample history and debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      shift      <= '0;
      level      <= 1'b0;
      level_last <= 1'b0;
    end else begin
      sync1      <= btn;
      sync2      <= sync1;
      shift      <= shift_d;
      if (&shift_d) begin
        level <= 1'b1;
      end else if (~|shift_d) begin
        level <= 1'b0;
      end
      level_last <= level;
    end
  end

  assign pulse_c = level & ~level_last;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM between the divider/buttons and the BCD counter /
// display scanner. Conditions the start/stop and lap/clear buttons, gates
// the divider tick into a count enable, clears the counter, freezes a lap
// value for display and blinks the live digits while paused.
// Ports:
//   clk, rst : clock, async active-low reset
//   bus      : slave side of stopwatch_ctrl_if
//              in : btn_ss, btn_lap, tick, q
//              out: cnt_en (comb), cnt_clr (reg), disp_val (comb),
//                   digit_blank (reg), state (reg)
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_BITS    = 8,
  parameter int unsigned DB_LEN      = 4,
  parameter int unsigned BLINK_TICKS = 2,
  parameter int unsigned STOP_AT_MAX = 1
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic                ss_p;
  logic                lap_p;

  sw_state_e           state_q;
  sw_state_e           state_d;
  logic [CNT_BITS-1:0] lap_reg;
  logic                cnt_clr_q;
  logic                cnt_clr_d;
  logic                lap_cap;
  logic [BLINK_W-1:0]  blink_cnt;
  logic [BLINK_W-1:0]  blink_cnt_d;
  logic                blink_phase;
  logic                blink_phase_d;
  logic [3:0]          blank_q;

  logic                counting;
  logic                max_hit;
  logic                stop_max;

  // Button conditioning.
  stopwatch_ctrl_debounce_onepulse #(.DB_LEN(DB_LEN)) u_db_ss (
    .clk     (clk),
    .rst     (rst),
    .btn     (bus.btn_ss),
    .pulse_c (ss_p)
  );

  stopwatch_ctrl_debounce_onepulse #(.DB_LEN(DB_LEN)) u_db_lap (
    .clk     (clk),
    .rst     (rst),
    .btn     (bus.btn_lap),
    .pulse_c (lap_p)
  );

  // Count gating and terminal-count detection.
  always_comb begin
    counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    max_hit  = (STOP_AT_MAX != 0) && (bus.q == CNT_BITS'(BCD_MAX));
    stop_max = bus.tick && counting && max_hit;
  end

  // Next state; start/stop always beats lap, terminal count beats lap.
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    lap_cap   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          cnt_clr_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (ss_p || stop_max) begin
          state_d = ST_PAUSE;
        end else if (lap_p) begin
          state_d = ST_LAP;
          lap_cap = 1'b1;
        end
      end
      ST_LAP: begin
        if (ss_p || stop_max) begin
          state_d = ST_PAUSE;
        end else if (lap_p) begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ss_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end
      end
    endcase
  end

  // Blink divider: runs only while staying in PAUSE, zeroed otherwise so
  // every pause starts with the digits visible.
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if ((state_q == ST_PAUSE) && (state_d == ST_PAUSE)) begin
      blink_cnt_d   = blink_cnt;
      blink_phase_d = blink_phase;
      if (bus.tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase;
        end else begin
          blink_cnt_d = blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  // State, lap capture, clear pulse and blink registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lap_reg     <= '0;
      cnt_clr_q   <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      blank_q     <= blank_mask(1'b0, 1'b0);
    end else begin
      state_q     <= state_d;
      cnt_clr_q   <= cnt_clr_d;
      blink_cnt   <= blink_cnt_d;
      blink_phase <= blink_phase_d;
      blank_q     <= blank_mask(state_d == ST_PAUSE, blink_phase_d);
      if (lap_cap) begin
        lap_reg <= bus.q;
      end
    end
  end

  assign bus.cnt_en      = bus.tick & counting & ~max_hit;
  assign bus.cnt_clr     = cnt_clr_q;
  assign bus.disp_val    = (state_q == ST_LAP) ? lap_reg : bus.q;
  assign bus.digit_blank = blank_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: one instance with STOP_AT_MAX=1 and a
// twin with STOP_AT_MAX=0 sharing the button/tick stimulus.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss;
  logic       btn_lap;
  logic       tick;
  logic [7:0] q;
  logic [7:0] q0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl_if #(.CNT_BITS(8)) bus ();
  stopwatch_ctrl_if #(.CNT_BITS(8)) bus0 ();

  assign bus.btn_ss   = btn_ss;
  assign bus.btn_lap  = btn_lap;
  assign bus.tick     = tick;
  assign bus.q        = q;
  assign bus0.btn_ss  = btn_ss;
  assign bus0.btn_lap = btn_lap;
  assign bus0.tick    = tick;
  assign bus0.q       = q0;

  stopwatch_ctrl #(.CNT_BITS(8), .DB_LEN(4), .BLINK_TICKS(2), .STOP_AT_MAX(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  stopwatch_ctrl #(.CNT_BITS(8), .DB_LEN(4), .BLINK_TICKS(2), .STOP_AT_MAX(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  typedef struct {
    logic       tick;
    logic [7:0] q;
    logic       en;
    logic [7:0] disp;
    logic [1:0] st;
    logic [3:0] blank;
  } vec_t;

  vec_t vecs [0:18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Each row is held for one clock; outputs compared mid-cycle.
  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick = vecs[i].tick;
      q    = vecs[i].q;
      q0   = vecs[i].q;
      @(negedge clk);
      check($sformatf("v%0d cnt_en", i), 32'(bus.cnt_en), 32'(vecs[i].en));
      check($sformatf("v%0d disp_val", i), 32'(bus.disp_val), 32'(vecs[i].disp));
      check($sformatf("v%0d state", i), 32'(bus.state), 32'(vecs[i].st));
      check($sformatf("v%0d digit_blank", i), 32'(bus.digit_blank), 32'(vecs[i].blank));
      @(posedge clk);
      #1;
    end
    tick = 1'b0;
  endtask

  // Hold buttons 10 clk; the transition must land on edge 2+DB_LEN+1 = 7.
  task automatic press_check(input logic ss, input logic lap, input logic [1:0] st_before,
                             input logic [1:0] st_after, input logic exp_clr);
    btn_ss  = ss;
    btn_lap = lap;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("press edge%0d state", k), 32'(bus.state),
            32'((k >= 7) ? st_after : st_before));
      check($sformatf("press edge%0d cnt_clr", k), 32'(bus.cnt_clr),
            32'(exp_clr && (k == 7)));
    end
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check("press settled state", 32'(bus.state), 32'(st_after));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h00, 1'b1, 8'h00, 2'b01, 4'hC};
    vecs[1]  = '{1'b0, 8'h01, 1'b0, 8'h01, 2'b01, 4'hC};
    vecs[2]  = '{1'b1, 8'h01, 1'b1, 8'h01, 2'b01, 4'hC};
    vecs[3]  = '{1'b1, 8'h02, 1'b1, 8'h02, 2'b01, 4'hC};
    vecs[4]  = '{1'b1, 8'h38, 1'b1, 8'h37, 2'b11, 4'hC};
    vecs[5]  = '{1'b0, 8'h39, 1'b0, 8'h37, 2'b11, 4'hC};
    vecs[6]  = '{1'b1, 8'h40, 1'b1, 8'h37, 2'b11, 4'hC};
    vecs[7]  = '{1'b0, 8'h41, 1'b0, 8'h41, 2'b01, 4'hC};
    vecs[8]  = '{1'b1, 8'h42, 1'b1, 8'h42, 2'b01, 4'hC};
    vecs[9]  = '{1'b1, 8'h42, 1'b0, 8'h42, 2'b10, 4'hC};
    vecs[10] = '{1'b1, 8'h42, 1'b0, 8'h42, 2'b10, 4'hC};
    vecs[11] = '{1'b0, 8'h42, 1'b0, 8'h42, 2'b10, 4'hF};
    vecs[12] = '{1'b1, 8'h42, 1'b0, 8'h42, 2'b10, 4'hF};
    vecs[13] = '{1'b1, 8'h42, 1'b0, 8'h42, 2'b10, 4'hF};
    vecs[14] = '{1'b0, 8'h42, 1'b0, 8'h42, 2'b10, 4'hC};
    vecs[15] = '{1'b1, 8'h42, 1'b0, 8'h42, 2'b10, 4'hC};
    vecs[16] = '{1'b1, 8'h42, 1'b0, 8'h42, 2'b10, 4'hC};
    vecs[17] = '{1'b0, 8'h42, 1'b0, 8'h42, 2'b10, 4'hF};
    vecs[18] = '{1'b1, 8'h56, 1'b1, 8'h55, 2'b11, 4'hC};

    rst     = 1'b0;
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    tick    = 1'b0;
    q       = 8'h00;
    q0      = 8'h00;

    // Reset values, with a tick present to show counting is off.
    repeat (3) @(posedge clk);
    #1;
    tick = 1'b1;
    q    = 8'h12;
    #2;
    check("reset state", 32'(bus.state), 32'(2'b00));
    check("reset cnt_en", 32'(bus.cnt_en), 32'(1'b0));
    check("reset cnt_clr", 32'(bus.cnt_clr), 32'(1'b0));
    check("reset digit_blank", 32'(bus.digit_blank), 32'(4'hC));
    check("reset disp_val", 32'(bus.disp_val), 32'(8'h12));
    tick = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Start, then cnt_en follows tick in RUN; a held button pulses once.
    press_check(1'b1, 1'b0, 2'b00, 2'b01, 1'b0);
    apply(0, 3);

    // Lap freezes 37 while q advances, second lap returns to live q.
    q  = 8'h37;
    q0 = 8'h37;
    press_check(1'b0, 1'b1, 2'b01, 2'b11, 1'b0);
    apply(4, 6);
    press_check(1'b0, 1'b1, 2'b11, 2'b01, 1'b0);
    apply(7, 8);

    // Both buttons together in RUN: start/stop wins, no clear.
    press_check(1'b1, 1'b1, 2'b01, 2'b10, 1'b0);

    // Pause blink every 2 ticks, then lap clears back to IDLE.
    apply(9, 17);
    press_check(1'b0, 1'b1, 2'b10, 2'b00, 1'b1);
    check("idle digit_blank", 32'(bus.digit_blank), 32'(4'hC));

    // Terminal count: stop variant pauses, wrap variant keeps running.
    press_check(1'b1, 1'b0, 2'b00, 2'b01, 1'b0);
    q    = 8'h99;
    q0   = 8'h99;
    tick = 1'b1;
    #2;
    check("max cnt_en stop", 32'(bus.cnt_en), 32'(1'b0));
    check("max cnt_en wrap", 32'(bus0.cnt_en), 32'(1'b1));
    @(posedge clk);
    #1;
    tick = 1'b0;
    check("max state stop", 32'(bus.state), 32'(2'b10));
    check("max state wrap", 32'(bus0.state), 32'(2'b01));
    check("max digit_blank", 32'(bus.digit_blank), 32'(4'hC));

    // Back to RUN, into LAP at 55, then async reset between edges.
    press_check(1'b1, 1'b0, 2'b10, 2'b01, 1'b0);
    q  = 8'h55;
    q0 = 8'h55;
    press_check(1'b0, 1'b1, 2'b01, 2'b11, 1'b0);
    apply(18, 18);
    tick = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async rst state", 32'(bus.state), 32'(2'b00));
    check("async rst digit_blank", 32'(bus.digit_blank), 32'(4'hC));
    check("async rst cnt_en", 32'(bus.cnt_en), 32'(1'b0));
    check("async rst disp_val", 32'(bus.disp_val), 32'(8'h56));
    check("async rst cnt_clr", 32'(bus.cnt_clr), 32'(1'b0));
    @(posedge clk);
    #1;
    rst  = 1'b1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post rst state", 32'(bus.state), 32'(2'b00));
    check("post rst state wrap", 32'(bus0.state), 32'(2'b00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
